// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the multiply/divide controller.
// Holds the FSM state set, op select and timeout defaults.
package muldiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_WRITE
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  localparam int unsigned START_TMO_DEF = 4;
  localparam int unsigned DONE_TMO_DEF  = 64;

  // Bits needed to hold the larger of two limits.
  function automatic int unsigned cnt_width(
    input int unsigned a,
    input int unsigned b
  );
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/muldiv_timer.sv
// Saturating cycle counter with an expiry flag.
// Reloads to zero on clear; expired once limit cycles have elapsed.
module muldiv_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   cnt_p1;

  // Clear on request, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current cycle is the limit-th one spent in the state.
  assign cnt_p1    = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
  assign expired_o = cnt_p1 >= {1'b0, limit_i};

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer between the control unit and the mult/div units.
// Owns HI/LO, launches one unit per op and guards it with timeouts.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned START_TMO = START_TMO_DEF,
  parameter int unsigned DONE_TMO  = DONE_TMO_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] divisor,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic        mult_control,
  input  logic        mult_busy,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        div_control,
  input  logic        div_busy,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        unit_reset,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall,
  output logic        done,
  output logic        div0,
  output logic        tmo_err
);

  localparam int unsigned CW = cnt_width(START_TMO, DONE_TMO);

  state_e      state_q;
  state_e      state_d;
  op_e         op_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        div0_q;
  logic        div0_d;
  logic        tmo_q;
  logic        tmo_d;
  logic        urst_q;
  logic        accept;
  logic        sel_busy;
  logic        expired;
  logic        tmr_clr;
  logic        idle_wr;
  logic [CW-1:0] limit;

  assign sel_busy = (op_q == OP_DIV) ? div_busy : mult_busy;
  assign tmr_clr  = state_d != state_q;
  assign limit    = (state_q == S_WAIT_BUSY) ? CW'(START_TMO)
                                             : CW'(DONE_TMO);
  assign idle_wr  = (state_q == S_IDLE) && !start;

  muldiv_timer #(
    .W(CW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (tmr_clr),
    .limit_i  (limit),
    .expired_o(expired)
  );

  // Next-state logic; a zero divisor is refused without a launch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    div0_d  = 1'b0;
    tmo_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((op == OP_DIV) && (divisor == 32'd0)) begin
            div0_d = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (sel_busy) begin
          state_d = S_WAIT_DONE;
        end else if (expired) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!sel_busy) begin
          state_d = S_WRITE;
        end else if (expired) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched op and the registered pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      div0_q  <= 1'b0;
      tmo_q   <= 1'b0;
      urst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= op_e'(op);
      end
      div0_q <= div0_d;
      tmo_q  <= tmo_d;
      urst_q <= tmo_d;
    end
  end

  // HI/LO: unit result on completion, MTHI/MTLO only when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == S_WRITE) begin
      hi_q <= (op_q == OP_DIV) ? div_hi : mult_hi;
      lo_q <= (op_q == OP_DIV) ? div_lo : mult_lo;
    end else if (idle_wr) begin
      if (wr_hi) begin
        hi_q <= wdata;
      end
      if (wr_lo) begin
        lo_q <= wdata;
      end
    end
  end

  assign mult_control = (state_q == S_LAUNCH) && (op_q == OP_MULT);
  assign div_control  = (state_q == S_LAUNCH) && (op_q == OP_DIV);
  assign stall        = state_q != S_IDLE;
  assign done         = state_q == S_WRITE;
  assign div0         = div0_q;
  assign tmo_err      = tmo_q;
  assign unit_reset   = urst_q;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl.
// Table vectors, hand sequences and random ops against a cycle-count model.
module tb_muldiv_ctrl;

  localparam int ST  = 4;
  localparam int DT  = 64;
  localparam int WIN = 80;

  typedef struct {
    logic        op;
    logic [31:0] dvs;
    int          lat;
    int          dly;
    bit          hang;
    logic [31:0] rhi;
    logic [31:0] rlo;
    int          e_done;
    int          e_tmo;
    int          e_div0;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] divisor = '0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] wdata = '0;
  logic        mult_control;
  logic        mult_busy;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic        div_control;
  logic        div_busy;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        unit_reset;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;
  logic        done;
  logic        div0;
  logic        tmo_err;

  // Unit model configuration, set by the stimulus.
  logic        cur_op = 1'b0;
  int          cur_lat = 1;
  int          cur_dly = 0;
  bit          cur_hang = 1'b0;
  logic [31:0] cur_rhi = '0;
  logic [31:0] cur_rlo = '0;
  logic        ubusy = 1'b0;
  int          ucnt = 0;
  int          upend = 0;

  int npass = 0;
  int ntot = 0;
  logic [31:0] mh;
  logic [31:0] ml;

  always #5 clk = ~clk;

  muldiv_ctrl #(
    .START_TMO(ST),
    .DONE_TMO (DT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .divisor     (divisor),
    .wr_hi       (wr_hi),
    .wr_lo       (wr_lo),
    .wdata       (wdata),
    .mult_control(mult_control),
    .mult_busy   (mult_busy),
    .mult_hi     (mult_hi),
    .mult_lo     (mult_lo),
    .div_control (div_control),
    .div_busy    (div_busy),
    .div_hi      (div_hi),
    .div_lo      (div_lo),
    .unit_reset  (unit_reset),
    .hi          (hi),
    .lo          (lo),
    .stall       (stall),
    .done        (done),
    .div0        (div0),
    .tmo_err     (tmo_err)
  );

  // Only the configured unit ever reports busy; the other one
  // presents distinct garbage results.
  assign mult_busy = ubusy && !cur_op;
  assign div_busy  = ubusy && cur_op;
  assign mult_hi   = cur_op ? 32'hDEAD0001 : cur_rhi;
  assign mult_lo   = cur_op ? 32'hDEAD0002 : cur_rlo;
  assign div_hi    = cur_op ? cur_rhi : 32'hBEEF0001;
  assign div_lo    = cur_op ? cur_rlo : 32'hBEEF0002;

  // Unit model: busy rises dly cycles after a launch, lasts lat cycles.
  always @(posedge clk) begin
    if (unit_reset) begin
      ubusy <= 1'b0;
      upend <= 0;
      ucnt  <= 0;
    end else if (mult_control || div_control) begin
      if (cur_dly == 0) begin
        ubusy <= 1'b1;
        ucnt  <= cur_lat - 1;
      end else begin
        upend <= cur_dly;
      end
    end else if (upend != 0) begin
      upend <= upend - 1;
      if (upend == 1) begin
        ubusy <= 1'b1;
        ucnt  <= cur_lat - 1;
      end
    end else if (ubusy && !cur_hang) begin
      if (ucnt == 0) ubusy <= 1'b0;
      else ucnt <= ucnt - 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) begin
      npass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic o, input logic [31:0] d,
    input int la, input int dl, input bit hg, input logic [31:0] rh,
    input logic [31:0] rl, input int ed, input int et, input int ez,
    input logic [31:0] eh, input logic [31:0] el);
    vec_t v;
    v.op = o; v.dvs = d; v.lat = la; v.dly = dl; v.hang = hg;
    v.rhi = rh; v.rlo = rl; v.e_done = ed; v.e_tmo = et;
    v.e_div0 = ez; v.e_hi = eh; v.e_lo = el;
    return v;
  endfunction

  // Expected outcome from the timing rules: latency+3, the two
  // timeout windows, and the zero-divisor refusal.
  function automatic vec_t ref_model(input vec_t v,
    input logic [31:0] h, input logic [31:0] l);
    vec_t r;
    r = v;
    r.e_done = 0; r.e_tmo = 0; r.e_div0 = 0;
    r.e_hi = h; r.e_lo = l;
    if (v.op && v.dvs == 0) begin
      r.e_div0 = 1;
    end else if (v.dly >= ST) begin
      r.e_tmo = 2 + ST;
    end else if (v.hang || (v.lat - 1 >= DT)) begin
      r.e_tmo = 3 + v.dly + DT;
    end else begin
      r.e_done = v.dly + v.lat + 3;
      r.e_hi = v.rhi;
      r.e_lo = v.rlo;
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int done_c = 0, done_n = 0, tmo_c = 0, tmo_n = 0, ur_n = 0;
    int d0_c = 0, d0_n = 0, sel_c = 0, sel_n = 0, uns_n = 0, st_n = 0;
    int exp_st;
    cur_op = v.op; cur_lat = v.lat; cur_dly = v.dly;
    cur_hang = v.hang; cur_rhi = v.rhi; cur_rlo = v.rlo;
    @(negedge clk);
    start = 1'b1; op = v.op; divisor = v.dvs;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        op = 1'($urandom_range(0, 1));
        divisor = $urandom;
      end
      if (done) begin if (done_c == 0) done_c = k; done_n++; end
      if (tmo_err) begin if (tmo_c == 0) tmo_c = k; tmo_n++; end
      if (unit_reset) ur_n++;
      if (div0) begin if (d0_c == 0) d0_c = k; d0_n++; end
      if (v.op ? div_control : mult_control) begin
        if (sel_c == 0) sel_c = k;
        sel_n++;
      end
      if (v.op ? mult_control : div_control) uns_n++;
      if (stall) st_n++;
    end
    exp_st = (v.e_done != 0) ? v.e_done :
             (v.e_tmo != 0) ? v.e_tmo - 1 : 0;
    chk({nm, " done_at"}, done_c, v.e_done);
    chk({nm, " done_cnt"}, done_n, (v.e_done != 0) ? 1 : 0);
    chk({nm, " tmo_at"}, tmo_c, v.e_tmo);
    chk({nm, " tmo_cnt"}, tmo_n, (v.e_tmo != 0) ? 1 : 0);
    chk({nm, " urst_cnt"}, ur_n, (v.e_tmo != 0) ? 1 : 0);
    chk({nm, " div0_at"}, d0_c, v.e_div0);
    chk({nm, " div0_cnt"}, d0_n, v.e_div0);
    chk({nm, " ctl_at"}, sel_c, (v.e_div0 != 0) ? 0 : 1);
    chk({nm, " ctl_cnt"}, sel_n, (v.e_div0 != 0) ? 0 : 1);
    chk({nm, " other_ctl"}, uns_n, 0);
    chk({nm, " stall_cyc"}, st_n, exp_st);
    chk({nm, " hi"}, hi, v.e_hi);
    chk({nm, " lo"}, lo, v.e_lo);
  endtask

  vec_t tbl[9];

  initial begin
    int dn;
    vec_t v;

    tbl[0] = mk(0, 0, 34, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB,
                37, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB);
    tbl[1] = mk(1, 7, 10, 0, 0, 2, 14, 13, 0, 0, 2, 32'hE);
    tbl[2] = mk(1, 0, 10, 0, 0, 9, 9, 0, 0, 1, 2, 32'hE);
    tbl[3] = mk(0, 0, 5, 0, 1, 32'hAAAAAAAA, 1, 0, 67, 0, 2, 32'hE);
    tbl[4] = mk(1, 5, 5, 10, 0, 7, 7, 0, 6, 0, 2, 32'hE);
    tbl[5] = mk(0, 3, 2, 3, 0, 32'h11, 32'h22, 8, 0, 0, 32'h11, 32'h22);
    tbl[6] = mk(0, 0, 64, 0, 0, 32'h33, 32'h44, 67, 0, 0, 32'h33, 32'h44);
    tbl[7] = mk(1, 9, 65, 0, 0, 5, 5, 0, 67, 0, 32'h33, 32'h44);
    tbl[8] = mk(1, 1, 3, 4, 0, 5, 5, 0, 6, 0, 32'h33, 32'h44);

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    chk("rst stall", stall, 0);
    chk("rst unit_reset", unit_reset, 1);
    chk("rst pulses", {done, div0, tmo_err, mult_control, div_control}, 0);
    reset = 1'b1;
    #1 chk("rel unit_reset", unit_reset, 1);
    @(negedge clk);
    chk("rel unit_reset drop", unit_reset, 0);

    // MTHI / MTLO while idle.
    wr_hi = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    wr_hi = 1'b0;
    chk("mthi hi", hi, 32'h12345678);
    chk("mthi lo", lo, 0);
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hA5A5C3C3;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("mthilo hi", hi, 32'hA5A5C3C3);
    chk("mthilo lo", lo, 32'hA5A5C3C3);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Writes and a second start during WAIT_DONE are ignored.
    cur_op = 0; cur_lat = 20; cur_dly = 0; cur_hang = 0;
    cur_rhi = 5; cur_rlo = 6;
    @(negedge clk);
    start = 1'b1; op = 1'b0;
    dn = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0; wr_hi = 1'b0;
      if (k == 4) begin
        wr_hi = 1'b1; wdata = 32'h12345678;
        start = 1'b1; op = 1'b1; divisor = 3;
      end
      if (k == 6) chk("busy write hi", hi, 32'h33);
      if (done) dn++;
      if (div_control) chk("busy start ignored", div_control, 0);
    end
    chk("busy write done_cnt", dn, 1);
    chk("busy write result hi", hi, 5);
    chk("busy write result lo", lo, 6);

    // Zero divisor together with a write: refused, write dropped.
    @(negedge clk);
    start = 1'b1; op = 1'b1; divisor = 0;
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hCAFEBABE;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    chk("div0 pulse", div0, 1);
    chk("div0 stall", stall, 0);
    chk("div0 hi", hi, 5);
    chk("div0 lo", lo, 6);
    @(negedge clk);
    chk("div0 one cycle", div0, 0);
    chk("div0 no launch", div_control, 0);

    // Reset while waiting for the unit.
    cur_op = 0; cur_lat = 30; cur_dly = 0;
    cur_rhi = 32'h77; cur_rlo = 32'h88;
    @(negedge clk);
    start = 1'b1; op = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("mid stall before", stall, 1);
    reset = 1'b0;
    #1;
    chk("mid rst stall", stall, 0);
    chk("mid rst hi", hi, 0);
    chk("mid rst lo", lo, 0);
    chk("mid rst unit_reset", unit_reset, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("mid rel unit_reset", unit_reset, 1);
    dn = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) chk("mid rel unit_reset drop", unit_reset, 0);
      if (done) dn++;
    end
    chk("mid rst no done", dn, 0);
    chk("mid rst hi after", hi, 0);

    // Random operations against the model.
    mh = hi; mh = 0; ml = 0;
    for (int i = 0; i < 30; i++) begin
      v.op = 1'($urandom_range(0, 1));
      v.dvs = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      v.lat = $urandom_range(1, 70);
      v.dly = $urandom_range(0, 6);
      v.hang = ($urandom_range(0, 7) == 0);
      v.rhi = $urandom;
      v.rlo = $urandom;
      v = ref_model(v, mh, ml);
      run_vec(v, $sformatf("rnd%0d", i));
      mh = v.e_hi;
      ml = v.e_lo;
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
